// File: rtl/mem_pipe_pkg.sv
// Shared types for the memory-access pipeline stage: FSM states, the held-op
// record, and the legal read-latency range.
package mem_pipe_pkg;

  localparam int RD_LAT_MIN    = 1;
  localparam int RD_LAT_MAX    = 4;
  // Data fields in the op record are sized for the widest supported datapath;
  // narrower instances zero-extend into them.
  localparam int OP_DATA_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOAD = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic                     writeback_enable;
    logic                     mem_read_enable;
    logic                     mem_write_enable;
    logic [OP_DATA_MAX_W-1:0] alu_result;
    logic [OP_DATA_MAX_W-1:0] write_data;
  } op_t;

  // An op with both memory bits set is a store, so only a pure read is a load.
  function automatic logic is_load(input op_t op);
    return op.mem_read_enable && !op.mem_write_enable;
  endfunction

endpackage

// File: rtl/mem_access_pipe_pipe_reg.sv
// Generic stage register: async reset, synchronous clear, load enable.
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load so a kill in the same cycle leaves the stage empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_pipe.sv
// Memory-access pipeline stage: holds one op, drives the memory port, waits
// RD_LAT cycles for load data and presents the writeback result.
module mem_access_pipe
  import mem_pipe_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              writeback_enable,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic              writeback_enable_out,
  output logic              mem_read_enable_out,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = 3;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_access_pipe: RD_LAT=%0d outside legal range", RD_LAT);
  end
  if (DATA_W > OP_DATA_MAX_W || DATA_W < 1) begin : g_bad_data_w
    $error("mem_access_pipe: DATA_W=%0d unsupported", DATA_W);
  end

  pipe_state_t      state;
  logic [CNT_W-1:0] cnt;
  op_t              op_p0;
  op_t              op_p1;
  logic             ready_slot;
  logic             capture;
  logic             load_done;

  // Incoming op packed into the shared record.
  always_comb begin
    op_p0                  = '0;
    op_p0.writeback_enable = writeback_enable;
    op_p0.mem_read_enable  = mem_read_enable;
    op_p0.mem_write_enable = mem_write_enable;
    op_p0.alu_result       = OP_DATA_MAX_W'(alu_result);
    op_p0.write_data       = OP_DATA_MAX_W'(write_data);
  end

  // The stage can take a new op when empty, when a non-load is retiring, or
  // on the cycle load data returns.
  assign load_done  = (state == ST_LOAD) && (cnt == '0);
  assign ready_slot = (state == ST_IDLE) || (state == ST_HOLD) || load_done;
  assign capture    = in_valid && ready_slot && !flush;
  assign in_ready   = ready_slot && !rst;

  // ---- stage p0 -> p1: op register
  pipe_reg #(
    .WIDTH($bits(op_t))
  ) u_op_reg (
    .clk (clk),
    .rst (rst),
    .en  (capture),
    .clr (flush),
    .d   (op_p0),
    .q   (op_p1)
  );

  // Control FSM and load-latency counter; flush returns to IDLE from anywhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (capture) begin
      if (is_load(op_p0)) begin
        state <= ST_LOAD;
        cnt   <= CNT_W'(RD_LAT);
      end else begin
        state <= ST_HOLD;
        cnt   <= '0;
      end
    end else if (ready_slot) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // ---- stage p1: memory port and writeback outputs
  if (DATA_W >= ADDR_W) begin : g_addr_trunc
    assign mem_addr = op_p1.alu_result[ADDR_W-1:0];
  end else begin : g_addr_zext
    assign mem_addr = ADDR_W'(op_p1.alu_result[DATA_W-1:0]);
  end

  if (DATA_W < OP_DATA_MAX_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^{op_p1.alu_result[OP_DATA_MAX_W-1:DATA_W],
                          op_p1.write_data[OP_DATA_MAX_W-1:DATA_W]};
  end

  assign mem_wdata = op_p1.write_data[DATA_W-1:0];

  // Output decode; flush suppresses every strobe in the cycle it is seen.
  always_comb begin
    mem_rd               = 1'b0;
    mem_wr               = 1'b0;
    out_valid            = 1'b0;
    writeback_enable_out = 1'b0;
    mem_read_enable_out  = 1'b0;
    result               = '0;
    if (!flush) begin
      mem_rd    = (state == ST_LOAD) && (cnt == CNT_W'(RD_LAT));
      mem_wr    = (state == ST_HOLD) && op_p1.mem_write_enable;
      out_valid = (state == ST_HOLD) || load_done;
    end
    if (out_valid) begin
      writeback_enable_out = op_p1.writeback_enable;
      mem_read_enable_out  = load_done;
      result               = load_done ? mem_rdata : op_p1.alu_result[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_mem_access_pipe.sv
// Randomized bench for mem_access_pipe with a cycle-scheduled reference model.
module tb_mem_access_pipe;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 17;
  localparam int RD_LAT = 2;
  localparam int NCYC   = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              writeback_enable;
  logic              mem_read_enable;
  logic              mem_write_enable;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] write_data;
  logic              flush;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              writeback_enable_out;
  logic              mem_read_enable_out;
  logic [DATA_W-1:0] result;

  always #5 clk = ~clk;

  mem_access_pipe #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .writeback_enable     (writeback_enable),
    .mem_read_enable      (mem_read_enable),
    .mem_write_enable     (mem_write_enable),
    .alu_result           (alu_result),
    .write_data           (write_data),
    .flush                (flush),
    .mem_addr             (mem_addr),
    .mem_rd               (mem_rd),
    .mem_wr               (mem_wr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .out_valid            (out_valid),
    .writeback_enable_out (writeback_enable_out),
    .mem_read_enable_out  (mem_read_enable_out),
    .result               (result)
  );

  // Expected observable activity per cycle, filled in when an op is accepted.
  typedef struct {
    bit              mem_rd;
    bit              mem_wr;
    bit              out_valid;
    bit              wbe;
    bit              mre;
    bit [ADDR_W-1:0] addr;
    bit [DATA_W-1:0] wdata;
    bit [DATA_W-1:0] result;
  } ev_t;

  ev_t             ev        [NCYC];
  bit              rdata_has [NCYC];
  bit [DATA_W-1:0] rdata_due [NCYC];
  int              cyc        = 0;
  int              ready_from = 0;
  int              n_vec      = 0;
  int              n_err      = 0;

  function automatic logic [DATA_W-1:0] mem_model(input logic [ADDR_W-1:0] a);
    if (a == 17'h00010) return 24'h777777;
    return {a[6:0] ^ 7'h55, a} ^ 24'hC3A50F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void clear_from(input int k0);
    for (int k = k0; k < k0 + RD_LAT + 3 && k < NCYC; k++) ev[k] = '{default: 0};
  endfunction

  // One clock cycle: drive inputs, check outputs against the schedule, then
  // advance the model (acceptance, flush, reset).
  task automatic step(input logic v, input logic wbe, input logic mre, input logic mwe,
                      input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wd,
                      input logic fl, input logic r, output bit acc);
    ev_t             e;
    bit              ld;
    bit [ADDR_W-1:0] a;
    acc = 0;
    @(negedge clk);
    rst              = r;
    in_valid         = v;
    writeback_enable = wbe;
    mem_read_enable  = mre;
    mem_write_enable = mwe;
    alu_result       = alu;
    write_data       = wd;
    flush            = fl;
    mem_rdata        = rdata_has[cyc] ? rdata_due[cyc] : DATA_W'($urandom);
    #1;
    if (r) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_wbe_out", writeback_enable_out, 0);
      chk("rst_mre_out", mem_read_enable_out, 0);
      chk("rst_result", result, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      clear_from(cyc + 1);
      ready_from = cyc + 1;
    end else begin
      e = ev[cyc];
      if (fl) e = '{default: 0};
      else chk("in_ready", in_ready, cyc >= ready_from);
      chk("out_valid", out_valid, e.out_valid);
      chk("mem_rd", mem_rd, e.mem_rd);
      chk("mem_wr", mem_wr, e.mem_wr);
      chk("wbe_out", writeback_enable_out, e.wbe);
      chk("mre_out", mem_read_enable_out, e.mre);
      if (e.out_valid) chk("result", result, e.result);
      if (e.mem_rd || e.mem_wr) chk("mem_addr", mem_addr, e.addr);
      if (e.mem_wr) chk("mem_wdata", mem_wdata, e.wdata);
      // Memory responder answers whatever read the DUT actually issued.
      if (mem_rd === 1'b1 && cyc + RD_LAT < NCYC) begin
        rdata_has[cyc + RD_LAT] = 1;
        rdata_due[cyc + RD_LAT] = mem_model(mem_addr);
      end
      if (fl) begin
        clear_from(cyc + 1);
        ready_from = cyc + 1;
      end else if (v && cyc >= ready_from && cyc + RD_LAT + 2 < NCYC) begin
        acc = 1;
        a   = alu[ADDR_W-1:0];
        ld  = mre && !mwe;
        if (ld) begin
          ev[cyc + 1].mem_rd               = 1;
          ev[cyc + 1].addr                 = a;
          ev[cyc + 1 + RD_LAT].out_valid   = 1;
          ev[cyc + 1 + RD_LAT].wbe         = wbe;
          ev[cyc + 1 + RD_LAT].mre         = 1;
          ev[cyc + 1 + RD_LAT].result      = mem_model(a);
          ready_from                       = cyc + 1 + RD_LAT;
        end else begin
          ev[cyc + 1].out_valid = 1;
          ev[cyc + 1].wbe       = wbe;
          ev[cyc + 1].result    = alu;
          ev[cyc + 1].mem_wr    = mwe;
          ev[cyc + 1].addr      = a;
          ev[cyc + 1].wdata     = wd;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, 0, 0, acc);
  endtask

  // Present an op and hold it until the model says it is taken.
  task automatic send(input logic wbe, input logic mre, input logic mwe,
                      input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wd);
    bit acc;
    int tries;
    acc   = 0;
    tries = 0;
    while (!acc && tries < RD_LAT + 4) begin
      step(1, wbe, mre, mwe, alu, wd, 0, 0, acc);
      tries++;
    end
  endtask

  initial begin
    bit              acc;
    bit              hv;
    bit              hwbe, hmre, hmwe;
    bit [DATA_W-1:0] halu, hwd;
    int              kind;
    rst = 1; in_valid = 0; writeback_enable = 0; mem_read_enable = 0;
    mem_write_enable = 0; alu_result = '0; write_data = '0; flush = 0; mem_rdata = '0;

    // Reset state
    step(0, 0, 0, 0, '0, '0, 0, 1, acc);
    step(1, 1, 1, 0, 24'h000010, '0, 0, 1, acc);
    idle(1);

    // ALU op, store, load, bubble, load+store
    send(1, 0, 0, 24'h00ABCD, 24'h0);
    idle(1);
    send(0, 0, 1, 24'h012345, 24'h5A5A5A);
    idle(1);
    send(1, 1, 0, 24'h000010, 24'h0);
    idle(RD_LAT + 1);
    send(0, 0, 0, 24'h123456, 24'h0);
    send(1, 1, 1, 24'h00F00F, 24'hA5A5A5);
    idle(2);

    // Load followed by a held ALU op
    send(1, 1, 0, 24'h000010, 24'h0);
    send(1, 0, 0, 24'h0BEEF0, 24'h0);
    send(1, 0, 0, 24'h0BEEF1, 24'h0);
    idle(2);

    // Flush one cycle after mem_rd; late data must be ignored
    send(1, 1, 0, 24'h000020, 24'h0);
    idle(1);
    step(0, 0, 0, 0, '0, '0, 1, 0, acc);
    idle(RD_LAT + 1);

    // Flush colliding with capture
    step(1, 1, 0, 0, 24'h000777, '0, 1, 0, acc);
    idle(2);

    // Reset in the middle of a load
    send(1, 1, 0, 24'h000030, 24'h0);
    idle(1);
    step(0, 0, 0, 0, '0, '0, 0, 1, acc);
    step(0, 0, 0, 0, '0, '0, 0, 1, acc);
    idle(RD_LAT + 2);

    // Random traffic with occasional flush and reset
    hv = 0; hwbe = 0; hmre = 0; hmwe = 0; halu = '0; hwd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!hv) begin
        hv   = ($urandom_range(0, 9) < 7);
        kind = $urandom_range(0, 4);
        hwbe = $urandom_range(0, 1);
        halu = DATA_W'($urandom);
        hwd  = DATA_W'($urandom);
        case (kind)
          0: begin hmre = 0; hmwe = 0; end
          1: begin hmre = 0; hmwe = 1; end
          2: begin hmre = 1; hmwe = 0; end
          3: begin hmre = 1; hmwe = 1; end
          default: begin hmre = 0; hmwe = 0; hwbe = 0; end
        endcase
      end
      step(hv, hwbe, hmre, hmwe, halu, hwd,
           ($urandom_range(0, 99) < 4), ($urandom_range(0, 199) == 0), acc);
      if (acc) hv = 0;
    end
    idle(RD_LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
